register_bridge: RTL and testbench
==================================

# register_bridge

Register bridge between the UART packet layer and the register file. Consumes received packet bytes from `UART_Packets` (`opRxStream`), decodes read/write commands and drives the `Registers` address, write-data and write-enable inputs. For every accepted command it builds a response packet and streams it back into the `UART_Packets` transmit port under the `opTxReady` handshake.

## Interface
- `BLOCK_WIDTH`, 32: register data width; multiple of 8; N = BLOCK_WIDTH/8 data bytes per command.
- `LOCAL_ADDRESS`, 8'h01: packet destination address this bridge answers to.

- `ipClk`  in  1  system clock; all logic on rising edge.
- `ipReset`  in  1  synchronous, active-high reset.
- `ipRxStream`  in  UART_PACKET  received byte stream; fields Source[7:0], Destination[7:0], Length[7:0], Data[7:0], SoP, EoP, Valid; no backpressure.
- `opTxStream`  out  UART_PACKET  response byte stream to packet transmitter.
- `ipTxReady`  in  1  transmitter accepts `opTxStream` this cycle.
- `opAddress`  out  8  register address.
- `opWrData`  out  BLOCK_WIDTH  register write data.
- `opWrEnable`  out  1  single-cycle write strobe.
- `ipRdData`  in  BLOCK_WIDTH  register read data; valid 1 cycle after `opAddress` is stable.

## Operation
- Command payload: byte0 = command (8'h00 read, 8'h01 write), byte1 = address, bytes 2..N+1 = write data, little-endian (LS byte first). Read: Length = 2. Write: Length = N+2.
- States: IDLE, RX_PAYLOAD, DROP, EXEC_WRITE, EXEC_READ, READ_WAIT, TX.
- IDLE: wait for Valid & SoP. If Destination == LOCAL_ADDRESS, capture Source as reply address, byte0 as command, go RX_PAYLOAD; else go DROP. A SoP byte with EoP set is a malformed packet -> stay IDLE.
- RX_PAYLOAD: byte counter counts Valid bytes; bytes shifted into address and data registers. On EoP: command 00 with count 2 -> EXEC_READ; command 01 with count N+2 -> EXEC_WRITE; anything else (unknown command, length mismatch, EoP early or late) -> IDLE, no register access, no response.
- Any SoP seen in RX_PAYLOAD restarts decoding with that byte as a new header (previous packet discarded).
- DROP: ignore bytes until Valid & EoP -> IDLE.
- EXEC_WRITE: `opWrEnable` = 1 for exactly one cycle with `opAddress`/`opWrData` held; load response = [8'h01, address]; -> TX.
- EXEC_READ: hold `opAddress` -> READ_WAIT (1 cycle) -> capture `ipRdData`, load response = [8'h00, address, N data bytes LS first]; -> TX.
- TX: `opTxStream`: Source = LOCAL_ADDRESS, Destination = captured Source, Length = response length (2 or N+2), SoP on first byte, EoP on last, Valid high throughout. Byte advances only on Valid & `ipTxReady`. After last byte accepted -> IDLE.
- Rx bytes arriving in any state other than IDLE/RX_PAYLOAD/DROP are discarded (sender must wait for the response).

## Timing
- Reset: state IDLE; `opWrEnable` 0; `opAddress` 0; `opWrData` 0; `opTxStream` all fields 0 (Valid 0); counters cleared. Reset mid-packet or mid-TX aborts immediately, no partial write, Valid drops next edge.
- Write: `opWrEnable` asserts 1 cycle after the EoP byte is sampled.
- Read: `opAddress` valid 1 cycle after EoP; `ipRdData` sampled 2 cycles after EoP; first response byte Valid 3 cycles after EoP.
- TX with `ipTxReady` held high: one byte per cycle; `ipTxReady` low holds current byte and all fields unchanged.
- `opWrEnable` never asserts outside EXEC_WRITE.

## Test plan
- Write: packet Dest 01, Src 05, Length 6, bytes [01, 10, 78, 56, 34, 12] -> single `opWrEnable` pulse, `opAddress`=10, `opWrData`=32'h12345678; response Dest 05, Length 2, bytes [01, 10].
- Read: `ipRdData`=32'hDEADBEEF for address 20; packet [00, 20] -> response Length 6, bytes [00, 20, EF, BE, AD, DE], SoP on first, EoP on last.
- Backpressure: read response with `ipTxReady` toggling 1-0-1 every cycle -> bytes unchanged while low, exactly 6 transfers, correct order.
- Filtering: Dest 02 packet, unknown command 07, write with Length 5 -> no `opWrEnable`, no Valid on `opTxStream`; next valid write still works.
- Reset mid-TX after 3 of 6 bytes -> Valid 0 next cycle, state IDLE; following read completes normally.
- Back-to-back writes to addresses 00 and FF -> two strobes, two 2-byte responses, in order.

Source files
------------

// File: rtl/register_bridge.sv
// UART packet <-> register file bridge: write strobe 1 cycle after EoP, read response Valid 3 cycles after EoP.
// Rx has no backpressure (bytes outside IDLE/RX_PAYLOAD/DROP are dropped); Tx byte advances only on ipTxReady.
package registerBridgePkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;
endpackage

module register_bridge
    import registerBridgePkg::*;
#(
    parameter int         BLOCK_WIDTH   = 32,
    parameter logic [7:0] LOCAL_ADDRESS = 8'h01
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  UART_PACKET             ipRxStream,
    output UART_PACKET             opTxStream,
    input  logic                   ipTxReady,
    output logic [7:0]             opAddress,
    output logic [BLOCK_WIDTH-1:0] opWrData,
    output logic                   opWrEnable,
    input  logic [BLOCK_WIDTH-1:0] ipRdData
);
    localparam int         N         = BLOCK_WIDTH / 8;
    localparam logic [7:0] READ_LEN  = 8'd2;
    localparam logic [7:0] WRITE_LEN = 8'(N + 2);

    typedef enum logic [2:0] {
        IDLE, RX_PAYLOAD, DROP, EXEC_WRITE, EXEC_READ, READ_WAIT, TX
    } state_t;

    state_t state, nextState, headerNext;

    logic [7:0]             replyAddr, rxCmd, rxLen, rxCount, rxAddress;
    logic [7:0]             rspCmd, rspLen, txIdx;
    logic [BLOCK_WIDTH-1:0] rxData, rxShifted, txShift;
    logic                   headerByte, headerOurs, payloadByte, lastByte;
    logic                   cmdRead, cmdWrite, txLast;

    assign headerByte  = ipRxStream.Valid & ipRxStream.SoP;
    assign headerOurs  = headerByte & ~ipRxStream.EoP & (ipRxStream.Destination == LOCAL_ADDRESS);
    assign payloadByte = (state == RX_PAYLOAD) & ipRxStream.Valid & ~ipRxStream.SoP;
    assign lastByte    = payloadByte & ipRxStream.EoP;
    // rxCount excludes the byte on the bus, so the total is rxCount + 1 when EoP arrives
    assign cmdRead   = (rxCmd == 8'h00) && (rxCount == READ_LEN - 8'd1)  && (rxLen == READ_LEN);
    assign cmdWrite  = (rxCmd == 8'h01) && (rxCount == WRITE_LEN - 8'd1) && (rxLen == WRITE_LEN);
    assign rxShifted = BLOCK_WIDTH'({ipRxStream.Data, rxData} >> 8);
    assign txLast    = (txIdx == rspLen - 8'd1);

    always_ff @(posedge ipClk) begin
        if (ipReset) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState  = state;
        opWrEnable = 1'b0;
        if (ipRxStream.EoP)                                 headerNext = IDLE;
        else if (ipRxStream.Destination == LOCAL_ADDRESS)   headerNext = RX_PAYLOAD;
        else                                                headerNext = DROP;
        case (state)
            IDLE:       if (headerByte) nextState = headerNext;
            RX_PAYLOAD: begin
                if (headerByte)     nextState = headerNext;
                else if (lastByte)  nextState = cmdRead ? EXEC_READ : (cmdWrite ? EXEC_WRITE : IDLE);
            end
            DROP:       if (ipRxStream.Valid && ipRxStream.EoP) nextState = IDLE;
            EXEC_WRITE: begin
                opWrEnable = 1'b1;
                nextState  = TX;
            end
            EXEC_READ:  nextState = READ_WAIT;
            READ_WAIT:  nextState = TX;
            TX:         if (ipTxReady && txLast) nextState = IDLE;
            default:    nextState = IDLE;
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            replyAddr <= '0;
            rxCmd     <= '0;
            rxLen     <= '0;
            rxCount   <= '0;
            rxAddress <= '0;
            rxData    <= '0;
            opAddress <= '0;
            opWrData  <= '0;
            rspCmd    <= '0;
            rspLen    <= '0;
            txIdx     <= '0;
            txShift   <= '0;
        end else begin
            if ((state == IDLE || state == RX_PAYLOAD) && headerOurs) begin
                replyAddr <= ipRxStream.Source;
                rxCmd     <= ipRxStream.Data;
                rxLen     <= ipRxStream.Length;
                rxCount   <= 8'd1;
            end else if (payloadByte) begin
                if (rxCount == 8'd1)      rxAddress <= ipRxStream.Data;
                else if (rxCount >= 8'd2) rxData    <= rxShifted;
                if (rxCount != 8'hFF)     rxCount   <= rxCount + 8'd1;
                // outputs change only for accepted commands
                if (lastByte && cmdRead) opAddress <= ipRxStream.Data;
                if (lastByte && cmdWrite) begin
                    opAddress <= rxAddress;
                    opWrData  <= rxShifted;
                end
            end
            case (state)
                EXEC_WRITE: begin
                    rspCmd <= 8'h01;
                    rspLen <= READ_LEN;
                    txIdx  <= '0;
                end
                READ_WAIT: begin
                    rspCmd  <= 8'h00;
                    rspLen  <= WRITE_LEN;
                    txShift <= ipRdData;
                    txIdx   <= '0;
                end
                TX: if (ipTxReady) begin
                    txIdx <= txIdx + 8'd1;
                    if (txIdx >= 8'd2) txShift <= txShift >> 8;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        opTxStream = '0;
        if (state == TX) begin
            opTxStream.Source      = LOCAL_ADDRESS;
            opTxStream.Destination = replyAddr;
            opTxStream.Length      = rspLen;
            opTxStream.SoP         = (txIdx == 8'd0);
            opTxStream.EoP         = txLast;
            opTxStream.Valid       = 1'b1;
            if (txIdx == 8'd0)      opTxStream.Data = rspCmd;
            else if (txIdx == 8'd1) opTxStream.Data = opAddress;
            else                    opTxStream.Data = txShift[7:0];
        end
    end
endmodule

// File: tb/tb_register_bridge.sv
// Self-checking bench for register_bridge: vector table, hand-written corner sequences, randomized packets vs model.
module tb_register_bridge;
    import registerBridgePkg::*;

    localparam logic [7:0] LOCAL = 8'h01;

    logic       ipClk = 1'b0;
    logic       ipReset;
    UART_PACKET ipRxStream, opTxStream;
    logic       ipTxReady;
    logic [7:0] opAddress;
    logic [31:0] opWrData, ipRdData;
    logic       opWrEnable;

    always #5 ipClk = ~ipClk;

    register_bridge #(.BLOCK_WIDTH(32), .LOCAL_ADDRESS(LOCAL)) dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipRxStream(ipRxStream), .opTxStream(opTxStream),
        .ipTxReady(ipTxReady), .opAddress(opAddress), .opWrData(opWrData),
        .opWrEnable(opWrEnable), .ipRdData(ipRdData)
    );

    int tests = 0;
    int fails = 0;
    int readyMode = 0;

    // emulated register file: read data one cycle after the address
    logic [31:0] benchMem [256];
    logic [31:0] modelMem [256];
    logic [31:0] rdLatch;
    assign ipRdData = rdLatch;
    always @(posedge ipClk) begin
        rdLatch <= benchMem[opAddress];
        if (opWrEnable) benchMem[opAddress] <= opWrData;
    end

    initial begin
        ipTxReady = 1'b1;
        forever begin
            @(posedge ipClk); #1;
            case (readyMode)
                0:       ipTxReady = 1'b1;
                1:       ipTxReady = ~ipTxReady;
                default: ipTxReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [41:0] txLog [$];
    logic [39:0] wrLog [$];
    UART_PACKET  prevTx;
    logic        prevStall = 1'b0;
    always @(negedge ipClk) begin
        if (prevStall && opTxStream.Valid) check("txHold", 64'(opTxStream), 64'(prevTx));
        prevStall <= opTxStream.Valid && !ipTxReady && !ipReset;
        prevTx    <= opTxStream;
        if (opTxStream.Valid && ipTxReady)
            txLog.push_back({opTxStream.SoP, opTxStream.EoP, opTxStream.Source,
                             opTxStream.Destination, opTxStream.Length, opTxStream.Data});
        if (opWrEnable) wrLog.push_back({opAddress, opWrData});
    end

    task automatic sendPkt(input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len,
                           input logic [63:0] b, input int nb, input bit withEop);
        UART_PACKET p;
        for (int i = 0; i < nb; i++) begin
            @(posedge ipClk); #1;
            p = '0;
            p.Source      = src;
            p.Destination = dst;
            p.Length      = len;
            p.Data        = b[8*i +: 8];
            p.SoP         = (i == 0);
            p.EoP         = withEop && (i == nb - 1);
            p.Valid       = 1'b1;
            ipRxStream    = p;
        end
        @(posedge ipClk); #1;
        ipRxStream = '0;
    endtask

    task automatic runTxn(input logic [7:0] dst, input logic [7:0] src, input logic [63:0] b, input int nb,
                          input bit expWr, input logic [7:0] wa, input logic [31:0] wd,
                          input logic [63:0] r, input int nr);
        int c;
        wrLog.delete();
        txLog.delete();
        sendPkt(dst, src, 8'(nb), b, nb, 1'b1);
        for (c = 0; c < 300; c++) begin
            @(negedge ipClk); #2;
            if (c >= 6 && txLog.size() >= nr && !opTxStream.Valid) break;
        end
        if (c == 300) begin
            tests++;
            fails++;
            $display("FAIL txnTimeout: got %0d bytes, expected %0d", txLog.size(), nr);
        end
        check("wrCount", 64'(wrLog.size()), 64'(expWr));
        if (expWr && wrLog.size() > 0) check("wrAddrData", 64'(wrLog[0]), 64'({wa, wd}));
        check("txCount", 64'(txLog.size()), 64'(nr));
        for (int i = 0; i < nr && i < txLog.size(); i++)
            check("txByte", 64'(txLog[i]), 64'({i == 0, i == nr - 1, LOCAL, src, 8'(nr), r[8*i +: 8]}));
        if (expWr) modelMem[wa] = wd;
    endtask

    // reference: what the packet means, byte list in, register effect and reply out
    function automatic void model(input logic [7:0] dst, input logic [63:0] b, input int nb,
                                  output bit wr, output logic [7:0] a, output logic [31:0] d,
                                  output logic [63:0] r, output int nr);
        wr = 1'b0;
        nr = 0;
        a  = b[15:8];
        d  = b[47:16];
        r  = '0;
        if (dst == LOCAL && nb == 2 && b[7:0] == 8'h00) begin
            r  = 64'({modelMem[a], a, 8'h00});
            nr = 6;
        end else if (dst == LOCAL && nb == 6 && b[7:0] == 8'h01) begin
            wr = 1'b1;
            r  = 64'({a, 8'h01});
            nr = 2;
        end
    endfunction

    typedef struct {
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [63:0] b;
        int          nb;
        bit          wr;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [63:0] r;
        int          nr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        ipReset    = 1'b1;
        ipRxStream = '0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            benchMem[i] <= v;
            modelMem[i] = v;
        end
        benchMem[8'h20] <= 32'hDEADBEEF;
        modelMem[8'h20] = 32'hDEADBEEF;

        vecs[0]  = '{8'h01, 8'h05, 64'h0000123456781001, 6, 1'b1, 8'h10, 32'h12345678, 64'h1001, 2};
        vecs[1]  = '{8'h01, 8'h07, 64'h2000, 2, 1'b0, 8'h00, 32'h0, 64'h0000DEADBEEF2000, 6};
        vecs[2]  = '{8'h02, 8'h05, 64'h0000123456781001, 6, 1'b0, 8'h00, 32'h0, 64'h0, 0};
        vecs[3]  = '{8'h01, 8'h05, 64'h2007, 2, 1'b0, 8'h00, 32'h0, 64'h0, 0};
        vecs[4]  = '{8'h01, 8'h05, 64'h0000003322113001, 5, 1'b0, 8'h00, 32'h0, 64'h0, 0};
        vecs[5]  = '{8'h01, 8'h09, 64'h0000DDCCBBAA3301, 6, 1'b1, 8'h33, 32'hDDCCBBAA, 64'h3301, 2};
        vecs[6]  = '{8'h01, 8'h05, 64'h002000, 3, 1'b0, 8'h00, 32'h0, 64'h0, 0};
        vecs[7]  = '{8'h01, 8'h05, 64'h1000, 2, 1'b0, 8'h00, 32'h0, 64'h0000123456781000, 6};
        vecs[8]  = '{8'h01, 8'h05, 64'h0000040302010001, 6, 1'b1, 8'h00, 32'h04030201, 64'h0001, 2};
        vecs[9]  = '{8'h01, 8'h05, 64'h00003CC35AA5FF01, 6, 1'b1, 8'hFF, 32'h3CC35AA5, 64'hFF01, 2};
        vecs[10] = '{8'h01, 8'h42, 64'hFF00, 2, 1'b0, 8'h00, 32'h0, 64'h00003CC35AA5FF00, 6};
        vecs[11] = '{8'h01, 8'h05, 64'h00, 1, 1'b0, 8'h00, 32'h0, 64'h0, 0};

        repeat (3) @(posedge ipClk);
        @(negedge ipClk);
        check("rstTxStream", 64'(opTxStream), 64'h0);
        check("rstWrEnable", 64'(opWrEnable), 64'h0);
        check("rstAddress", 64'(opAddress), 64'h0);
        check("rstWrData", 64'(opWrData), 64'h0);
        @(posedge ipClk); #1;
        ipReset = 1'b0;

        for (int k = 0; k < 12; k++)
            runTxn(vecs[k].dst, vecs[k].src, vecs[k].b, vecs[k].nb, vecs[k].wr,
                   vecs[k].wa, vecs[k].wd, vecs[k].r, vecs[k].nr);

        // write strobe timing relative to the EoP sample edge
        sendPkt(LOCAL, 8'h05, 8'd6, 64'h0000CAFEF00D4401, 6, 1'b1);
        @(negedge ipClk);
        check("wrStrobeT1", 64'(opWrEnable), 64'h1);
        check("wrAddrT1", 64'({opAddress, opWrData}), 64'({8'h44, 32'hCAFEF00D}));
        @(negedge ipClk);
        check("wrStrobeT2", 64'(opWrEnable), 64'h0);
        check("wrRspValidT2", 64'(opTxStream.Valid), 64'h1);
        repeat (8) @(negedge ipClk);
        modelMem[8'h44] = 32'hCAFEF00D;

        // read response timing
        sendPkt(LOCAL, 8'h05, 8'd2, 64'h4400, 2, 1'b1);
        @(negedge ipClk);
        check("rdAddrT1", 64'(opAddress), 64'h44);
        check("rdValidT1", 64'(opTxStream.Valid), 64'h0);
        @(negedge ipClk);
        check("rdValidT2", 64'(opTxStream.Valid), 64'h0);
        @(negedge ipClk);
        check("rdFirstT3", 64'({opTxStream.Valid, opTxStream.SoP, opTxStream.Data}), 64'h300);
        repeat (10) @(negedge ipClk);

        // backpressure: ready toggles every cycle
        readyMode = 1;
        runTxn(LOCAL, 8'h05, 64'h2000, 2, 1'b0, 8'h00, 32'h0, 64'h0000DEADBEEF2000, 6);
        readyMode = 0;

        // a new SoP discards a half-received write
        sendPkt(LOCAL, 8'h05, 8'd6, 64'h115001, 3, 1'b0);
        runTxn(LOCAL, 8'h06, 64'h2000, 2, 1'b0, 8'h00, 32'h0, 64'h0000DEADBEEF2000, 6);

        // reset after 3 of 6 response bytes
        txLog.delete();
        sendPkt(LOCAL, 8'h05, 8'd2, 64'h2000, 2, 1'b1);
        for (int c = 0; c < 40; c++) begin
            @(negedge ipClk); #2;
            if (txLog.size() >= 3) break;
        end
        check("preResetBytes", 64'(txLog.size()), 64'd3);
        ipReset = 1'b1;
        @(posedge ipClk); #1;
        ipReset = 1'b0;
        @(negedge ipClk);
        check("midTxResetStream", 64'(opTxStream), 64'h0);
        check("midTxResetAddr", 64'(opAddress), 64'h0);
        v = 32'(txLog.size());
        repeat (5) @(negedge ipClk);
        check("noTxAfterReset", 64'(txLog.size()), 64'(v));
        runTxn(LOCAL, 8'h05, 64'h1000, 2, 1'b0, 8'h00, 32'h0, 64'h0000123456781000, 6);

        // randomized packets against the model, random ready
        readyMode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [7:0]  dst, src, a;
            logic [63:0] b, r;
            logic [31:0] d;
            int          nb, kind, nr;
            bit          wr;
            kind = int'($urandom_range(0, 5));
            b    = {$urandom, $urandom};
            b[15:8] = 8'($urandom_range(0, 7));
            src  = 8'($urandom);
            dst  = LOCAL;
            case (kind)
                0, 5: begin b[7:0] = 8'h00; nb = 2; end
                1:    begin b[7:0] = 8'h01; nb = 6; end
                2:    begin b[7:0] = 8'h01; nb = 6; dst = 8'($urandom_range(2, 255)); end
                3:    begin b[7:0] = 8'($urandom_range(2, 255)); nb = int'($urandom_range(2, 6)); end
                default: begin
                    b[7:0] = 8'($urandom_range(0, 1));
                    nb = (b[7:0] == 8'h00) ? int'($urandom_range(3, 5)) : int'($urandom_range(2, 5));
                end
            endcase
            model(dst, b, nb, wr, a, d, r, nr);
            runTxn(dst, src, b, nb, wr, a, d, r, nr);
        end
        readyMode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
